// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM state encoding and default operand widths for the fp add sequencer.
package fp_pkg;

  localparam int MANTISSA_SIZE_DEF = 23;
  localparam int EXPONENT_SIZE_DEF = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COMPARE    = 3'd1,
    ALIGN_LOAD = 3'd2,
    ALIGN_WAIT = 3'd3,
    ADD        = 3'd4,
    NORM_LOAD  = 3'd5,
    NORM_WAIT  = 3'd6,
    DONE       = 3'd7
  } fp_state_e;

endpackage

// File: rtl/fp_exp_compare.sv
// fp_exp_compare: orders two operands by exponent (A wins ties) and returns the exponent gap.
module fp_exp_compare
  import fp_pkg::*;
#(
  parameter int Mantissa_Size = MANTISSA_SIZE_DEF,
  parameter int Exponent_Size = EXPONENT_SIZE_DEF
) (
  input  logic [Mantissa_Size:0]   mantissa_a,
  input  logic [Mantissa_Size:0]   mantissa_b,
  input  logic [Exponent_Size-1:0] exponent_a,
  input  logic [Exponent_Size-1:0] exponent_b,
  output logic [Mantissa_Size:0]   big_mantissa,
  output logic [Exponent_Size-1:0] big_exponent,
  output logic [Mantissa_Size:0]   small_mantissa,
  output logic [Exponent_Size-1:0] small_exponent,
  output logic [Exponent_Size-1:0] diff
);

  always_comb begin
    if (exponent_a >= exponent_b) begin
      big_mantissa   = mantissa_a;
      big_exponent   = exponent_a;
      small_mantissa = mantissa_b;
      small_exponent = exponent_b;
    end else begin
      big_mantissa   = mantissa_b;
      big_exponent   = exponent_b;
      small_mantissa = mantissa_a;
      small_exponent = exponent_a;
    end
    diff = big_exponent - small_exponent;
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: sequences a floating-point magnitude add around an external shift_register.
// Define SHIFT_TIMEOUT_EN to abort the shift-register wait states after Mantissa_Size+4 cycles.
module fp_add_sequencer
  import fp_pkg::*;
#(
  parameter int Mantissa_Size = MANTISSA_SIZE_DEF,
  parameter int Exponent_Size = EXPONENT_SIZE_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [Mantissa_Size:0]   mantissa_a,
  input  logic [Mantissa_Size:0]   mantissa_b,
  input  logic [Exponent_Size-1:0] exponent_a,
  input  logic [Exponent_Size-1:0] exponent_b,
  output logic                     busy,
  output logic                     result_valid,
  output logic [Mantissa_Size:0]   result_mantissa,
  output logic [Exponent_Size-1:0] result_exponent,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     sr_enable,
  output logic                     sr_load,
  output logic                     sr_direction,
  output logic [Mantissa_Size:0]   sr_mantissa,
  output logic [Exponent_Size-1:0] sr_exponent,
  output logic [Exponent_Size-1:0] sr_no_of_shifts,
  input  logic [Mantissa_Size:0]   sr_shiftedMantissa,
  input  logic [Exponent_Size-1:0] sr_shiftedExponent,
  input  logic                     sr_done,
  output fp_state_e                dbg_state
);

  localparam logic [Exponent_Size-1:0] MAX_ALIGN = Exponent_Size'(Mantissa_Size + 1);
  localparam logic [Exponent_Size-1:0] EXP_ONES  = '1;

  fp_state_e state, next_state;

  logic [Mantissa_Size:0]   op_man_a, op_man_b, man_a, man_b, acc_man, res_man;
  logic [Exponent_Size-1:0] op_exp_a, op_exp_b, exp_a, exp_b, diff_r, acc_exp, res_exp;
  logic                     ovf_r, unf_r, armed;
  logic [Mantissa_Size:0]   c_big_man, c_small_man;
  logic [Exponent_Size-1:0] c_big_exp, c_small_exp, c_diff;
  logic [Mantissa_Size+1:0] sum;
  logic [Exponent_Size-1:0] exp_inc;
  logic                     carry, ovf_hit, sr_ok, timeout;

  fp_exp_compare #(
    .Mantissa_Size(Mantissa_Size),
    .Exponent_Size(Exponent_Size)
  ) u_cmp (
    .mantissa_a    (op_man_a),
    .mantissa_b    (op_man_b),
    .exponent_a    (op_exp_a),
    .exponent_b    (op_exp_b),
    .big_mantissa  (c_big_man),
    .big_exponent  (c_big_exp),
    .small_mantissa(c_small_man),
    .small_exponent(c_small_exp),
    .diff          (c_diff)
  );

  assign sum     = {1'b0, man_a} + {1'b0, man_b};
  assign carry   = sum[Mantissa_Size+1];
  assign exp_inc = exp_a + 1'b1;
  assign ovf_hit = carry && (exp_inc == EXP_ONES);

  // Handshake: sr_load is a one-cycle request qualifying sr_mantissa/sr_exponent/
  // sr_no_of_shifts; sr_done is trusted only once armed (second WAIT cycle on),
  // because the shifter may still present the previous operation's done.
  assign sr_ok = armed && sr_done;

`ifdef SHIFT_TIMEOUT_EN
  localparam int TW = $clog2(Mantissa_Size + 4);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(Mantissa_Size + 3);
  logic [TW-1:0] wait_cnt;
  assign timeout = (wait_cnt == TIMEOUT_LAST);
`else
  assign timeout = 1'b0;
`endif

  assign result_mantissa = res_man;
  assign result_exponent = res_exp;
  assign overflow        = ovf_r;
  assign underflow       = unf_r;
  assign dbg_state       = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state      = state;
    busy            = (state != IDLE);
    sr_enable       = (state != IDLE);
    result_valid    = (state == DONE);
    sr_load         = 1'b0;
    sr_direction    = 1'b0;
    sr_mantissa     = '0;
    sr_exponent     = '0;
    sr_no_of_shifts = '0;
    case (state)
      IDLE:       if (start) next_state = COMPARE;
      COMPARE:    next_state = (c_diff == '0 || c_diff > MAX_ALIGN) ? ADD : ALIGN_LOAD;
      ALIGN_LOAD: begin
        next_state      = ALIGN_WAIT;
        sr_load         = 1'b1;
        sr_direction    = 1'b1;
        sr_mantissa     = man_b;
        sr_exponent     = exp_b;
        sr_no_of_shifts = diff_r;
      end
      ALIGN_WAIT: begin
        sr_direction = 1'b1;
        if (sr_ok)        next_state = ADD;
        else if (timeout) next_state = DONE;
      end
      ADD: begin
        // Any sum that is zero, carried, or already normalized finishes here.
        if (ovf_hit || sum == '0 || carry || sum[Mantissa_Size]) next_state = DONE;
        else                                                      next_state = NORM_LOAD;
      end
      NORM_LOAD: begin
        next_state  = NORM_WAIT;
        sr_load     = 1'b1;
        sr_mantissa = acc_man;
        sr_exponent = acc_exp;
      end
      NORM_WAIT:  if (sr_ok || timeout) next_state = DONE;
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_man_a <= '0; op_man_b <= '0; op_exp_a <= '0; op_exp_b <= '0;
      man_a    <= '0; man_b    <= '0; exp_a    <= '0; exp_b    <= '0;
      diff_r   <= '0; acc_man  <= '0; acc_exp  <= '0;
      res_man  <= '0; res_exp  <= '0; ovf_r    <= 1'b0; unf_r <= 1'b0;
      armed    <= 1'b0;
`ifdef SHIFT_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          op_man_a <= mantissa_a;
          op_man_b <= mantissa_b;
          op_exp_a <= exponent_a;
          op_exp_b <= exponent_b;
        end
        COMPARE: begin
          man_a  <= c_big_man;
          exp_a  <= c_big_exp;
          man_b  <= (c_diff > MAX_ALIGN) ? '0 : c_small_man;
          exp_b  <= c_small_exp;
          diff_r <= c_diff;
        end
        ALIGN_LOAD, NORM_LOAD: begin
          armed <= 1'b0;
`ifdef SHIFT_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ALIGN_WAIT: begin
          armed <= 1'b1;
`ifdef SHIFT_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
`endif
          if (sr_ok) begin
            man_b <= sr_shiftedMantissa;
          end else if (timeout) begin
            res_man <= '0; res_exp <= '0; ovf_r <= 1'b1; unf_r <= 1'b1;
          end
        end
        ADD: begin
          if (ovf_hit) begin
            res_man <= '0; res_exp <= EXP_ONES; ovf_r <= 1'b1; unf_r <= 1'b0;
          end else if (sum == '0) begin
            res_man <= '0; res_exp <= '0; ovf_r <= 1'b0; unf_r <= 1'b0;
          end else if (carry) begin
            res_man <= sum[Mantissa_Size+1:1]; res_exp <= exp_inc;
            ovf_r   <= 1'b0;                   unf_r   <= 1'b0;
          end else if (sum[Mantissa_Size]) begin
            res_man <= sum[Mantissa_Size:0]; res_exp <= exp_a;
            ovf_r   <= 1'b0;                 unf_r   <= 1'b0;
          end else begin
            acc_man <= sum[Mantissa_Size:0];
            acc_exp <= exp_a;
          end
        end
        NORM_WAIT: begin
          armed <= 1'b1;
`ifdef SHIFT_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
`endif
          if (sr_ok) begin
            // The shifter returns 0/0 when normalization would drop below exponent 1.
            res_man <= sr_shiftedMantissa;
            res_exp <= sr_shiftedExponent;
            ovf_r   <= 1'b0;
            unf_r   <= (sr_shiftedMantissa == '0) && (sr_shiftedExponent == '0);
          end else if (timeout) begin
            res_man <= '0; res_exp <= '0; ovf_r <= 1'b1; unf_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed and random adds against a behavioural reference and shift_register model.
module tb_fp_add_sequencer;
  import fp_pkg::*;

  localparam int M  = 23;
  localparam int E  = 8;
  localparam int MW = M + 1;
  localparam int W  = MW + E + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [M:0]    mantissa_a = '0, mantissa_b = '0;
  logic [E-1:0]  exponent_a = '0, exponent_b = '0;
  logic          busy, result_valid, overflow, underflow;
  logic [M:0]    result_mantissa;
  logic [E-1:0]  result_exponent;
  logic          sr_enable, sr_load, sr_direction;
  logic [M:0]    sr_mantissa;
  logic [E-1:0]  sr_exponent, sr_no_of_shifts;
  logic [M:0]    sr_shiftedMantissa;
  logic [E-1:0]  sr_shiftedExponent;
  logic          sr_done;
  fp_state_e     dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  fp_add_sequencer #(.Mantissa_Size(M), .Exponent_Size(E)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mantissa_a(mantissa_a), .mantissa_b(mantissa_b),
    .exponent_a(exponent_a), .exponent_b(exponent_b),
    .busy(busy), .result_valid(result_valid),
    .result_mantissa(result_mantissa), .result_exponent(result_exponent),
    .overflow(overflow), .underflow(underflow),
    .sr_enable(sr_enable), .sr_load(sr_load), .sr_direction(sr_direction),
    .sr_mantissa(sr_mantissa), .sr_exponent(sr_exponent), .sr_no_of_shifts(sr_no_of_shifts),
    .sr_shiftedMantissa(sr_shiftedMantissa), .sr_shiftedExponent(sr_shiftedExponent),
    .sr_done(sr_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shift_register model ----------------
  // Done stays high after completion and is cleared one cycle after the next load.
  logic         sr_hang = 1'b0;
  logic         pend;
  int           cnt;
  logic         ld;
  logic [M:0]   lm, sm_t;
  logic [E-1:0] le, ln, se_t;

  function automatic void sr_compute(input logic dir, input logic [M:0] m_in,
                                     input logic [E-1:0] e_in, input logic [E-1:0] n,
                                     output logic [M:0] m_out, output logic [E-1:0] e_out);
    int lz;
    lz = 0;
    if (dir) begin
      m_out = m_in >> n;
      e_out = e_in + n;
    end else if (m_in == '0) begin
      m_out = '0;
      e_out = '0;
    end else begin
      m_out = m_in;
      while (!m_out[M]) begin
        m_out = m_out << 1;
        lz++;
      end
      if (lz >= int'(e_in)) begin
        m_out = '0;
        e_out = '0;
      end else begin
        e_out = e_in - E'(lz);
      end
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_done <= 1'b0; pend <= 1'b0; cnt <= 0;
      sr_shiftedMantissa <= '0; sr_shiftedExponent <= '0;
    end else if (sr_load) begin
      pend <= 1'b1;
      cnt  <= int'($urandom_range(2, 6));
      lm   <= sr_mantissa; le <= sr_exponent; ln <= sr_no_of_shifts; ld <= sr_direction;
    end else if (pend && !sr_hang) begin
      if (cnt <= 1) begin
        sr_compute(ld, lm, le, ln, sm_t, se_t);
        sr_shiftedMantissa <= sm_t;
        sr_shiftedExponent <= se_t;
        sr_done <= 1'b1;
        pend    <= 1'b0;
      end else begin
        sr_done <= 1'b0;
        cnt     <= cnt - 1;
      end
    end else if (sr_hang) begin
      sr_done <= 1'b0;
    end
  end

  int load_cnt = 0;
  int last_shift = -1;
  always @(negedge clk) begin
    if (sr_load === 1'b1) begin
      load_cnt++;
      if (sr_direction === 1'b1) last_shift = int'(sr_no_of_shifts);
    end
  end

  // ---------------- reference model ----------------
  function automatic void ref_add(input int ma_i, input int ea_i, input int mb_i, input int eb_i,
                                  output int rm, output int re, output int rovf, output int runf,
                                  output int rloads, output int rshift);
    int ma, ea, mb, eb, d, s, e, lz;
    bit cy;
    if (eb_i > ea_i) begin
      ma = mb_i; ea = eb_i; mb = ma_i; eb = ea_i;
    end else begin
      ma = ma_i; ea = ea_i; mb = mb_i; eb = eb_i;
    end
    d = ea - eb; rloads = 0; rshift = -1; rovf = 0; runf = 0;
    if (d > MW) mb = 0;
    else if (d > 0) begin
      mb = mb >> d; rloads = 1; rshift = d;
    end
    s = ma + mb; e = ea; cy = 0;
    if (s >= (1 << MW)) begin
      s = s >> 1; e = e + 1; cy = 1;
    end
    if (cy && e == (1 << E) - 1) begin
      rm = 0; re = e; rovf = 1;
    end else if (s == 0) begin
      rm = 0; re = 0;
    end else if (s >= (1 << M)) begin
      rm = s; re = e;
    end else begin
      rloads++;
      lz = 0;
      while (s < (1 << M)) begin
        s = s << 1; lz++;
      end
      if (lz >= e) begin
        rm = 0; re = 0; runf = 1;
      end else begin
        rm = s; re = e - lz;
      end
    end
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic run_op(input string tag, input logic [M:0] ma, input logic [E-1:0] ea,
                        input logic [M:0] mb, input logic [E-1:0] eb, input bit poke);
    int rm, re, rovf, runf, rloads, rshift, base, cyc;
    logic [W-1:0] got, want;
    ref_add(int'(ma), int'(ea), int'(mb), int'(eb), rm, re, rovf, runf, rloads, rshift);
    exp_q.push_back({MW'(rm), E'(re), rovf[0], runf[0]});
    base = load_cnt;
    @(negedge clk);
    mantissa_a = ma; exponent_a = ea; mantissa_b = mb; exponent_b = eb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".sr_enable"}, 32'(sr_enable), 32'd1);
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < 200) begin
      if (poke && cyc == 1) begin
        start = 1'b1; mantissa_a = MW'($urandom); exponent_a = E'($urandom_range(1, 254));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, ".result_valid"}, 32'(result_valid), 32'd1);
    want = exp_q.pop_front();
    got  = {result_mantissa, result_exponent, overflow, underflow};
    check({tag, ".mantissa"}, 32'(got[W-1 -: MW]), 32'(want[W-1 -: MW]));
    check({tag, ".exponent"}, 32'(got[E+1:2]), 32'(want[E+1:2]));
    check({tag, ".overflow"}, 32'(got[1]), 32'(want[1]));
    check({tag, ".underflow"}, 32'(got[0]), 32'(want[0]));
    check({tag, ".sr_loads"}, 32'(load_cnt - base), 32'(rloads));
    if (rshift >= 0) check({tag, ".align_shift"}, 32'(last_shift), 32'(rshift));
    @(negedge clk);
    check({tag, ".valid_pulse"}, 32'(result_valid), 32'd0);
    check({tag, ".busy_clear"}, 32'(busy), 32'd0);
    check({tag, ".held"}, 32'(result_mantissa), 32'(rm));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, n, mode;
    logic [M:0]   ma, mb;
    logic [E-1:0] ea, eb;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.state", 32'(dbg_state), 32'(IDLE));
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.valid", 32'(result_valid), 32'd0);
    check("rst.sr_load", 32'(sr_load), 32'd0);
    check("rst.mantissa", 32'(result_mantissa), 32'd0);
    check("rst.exponent", 32'(result_exponent), 32'd0);
    check("rst.flags", 32'({overflow, underflow}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("carry_align", 24'hC00000, 8'd6, 24'h800000, 8'd5, 1'b0);
    run_op("swap", 24'h800000, 8'd5, 24'hC00000, 8'd6, 1'b1);
    run_op("equal_exp", 24'h800000, 8'd10, 24'h800000, 8'd10, 1'b0);
    run_op("normalize", 24'h030000, 8'd6, 24'h030000, 8'd6, 1'b0);
    run_op("norm_underflow", 24'h030000, 8'd2, 24'h030000, 8'd2, 1'b0);
    run_op("far_diff30", 24'h800000, 8'd40, 24'hFFFFFF, 8'd10, 1'b0);
    run_op("diff24", 24'h800000, 8'd30, 24'hFFFFFF, 8'd6, 1'b0);
    run_op("diff25", 24'h800000, 8'd31, 24'hFFFFFF, 8'd6, 1'b0);
    run_op("overflow", 24'h800000, 8'd254, 24'h800000, 8'd254, 1'b0);
    run_op("zero_sum", 24'h000000, 8'd9, 24'h000000, 8'd9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 3));
      ma = MW'($urandom) | 24'h800000;
      mb = MW'($urandom) | 24'h800000;
      ea = E'($urandom_range(1, 254));
      eb = E'($urandom_range(1, 254));
      if (mode == 1) eb = ea;
      if (mode == 2) begin
        ma = MW'($urandom & 32'h7FFFFF) >> $urandom_range(0, 12);
        mb = MW'($urandom & 32'h7FFFFF) >> $urandom_range(0, 12);
        ea = E'($urandom_range(1, 14));
        eb = E'($urandom_range(1, 14));
      end
      if (mode == 3) begin
        ea = 8'd254;
        eb = E'($urandom_range(252, 254));
      end
      run_op("rand", ma, ea, mb, eb, i[0]);
    end

    // reset while waiting for the aligning shift
    @(negedge clk);
    mantissa_a = 24'hC00000; exponent_a = 8'd6; mantissa_b = 24'h800000; exponent_b = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (dbg_state !== ALIGN_WAIT && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst.reached_wait", 32'(dbg_state), 32'(ALIGN_WAIT));
    #2 reset_n = 1'b0;
    #1;
    check("midrst.state", 32'(dbg_state), 32'(IDLE));
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.sr_load", 32'(sr_load), 32'd0);
    check("midrst.mantissa", 32'(result_mantissa), 32'd0);
    @(negedge clk);
    check("midrst.held_idle", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("after_reset", 24'hC00000, 8'd6, 24'h800000, 8'd5, 1'b0);

`ifdef SHIFT_TIMEOUT_EN
    sr_hang = 1'b1;
    @(negedge clk);
    mantissa_a = 24'hC00000; exponent_a = 8'd6; mantissa_b = 24'h800000; exponent_b = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (sr_load !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo.sr_load_seen", 32'(sr_load), 32'd1);
    n = 0;
    while (result_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo.latency", 32'(n), 32'(M + 5));
    check("tmo.flags", 32'({overflow, underflow}), 32'b11);
    check("tmo.mantissa", 32'(result_mantissa), 32'd0);
    check("tmo.exponent", 32'(result_exponent), 32'd0);
    sr_hang = 1'b0;
    @(negedge clk);
    run_op("after_timeout", 24'h030000, 8'd6, 24'h030000, 8'd6, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_sequencer.md
FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

Interface
REQ-001 SHALL have parameter Mantissa_Size, default 23, fraction width; operand mantissas are Mantissa_Size+1 bits including the hidden bit.
REQ-002 SHALL have parameter Exponent_Size, default 8, biased exponent width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 mantissa_a, mantissa_b  in  Mantissa_Size+1  operand magnitudes.
REQ-007 exponent_a, exponent_b  in  Exponent_Size  operand exponents.
REQ-008 busy  out  1  high from the cycle after an accepted start until result_valid.
REQ-009 result_valid  out  1  one-cycle pulse when the result is valid.
REQ-010 result_mantissa / result_exponent  out  Mantissa_Size+1 / Exponent_Size  result; held until the next result_valid.
REQ-011 overflow, underflow  out  1  status flags, valid with result_valid.
REQ-012 sr_enable, sr_load, sr_direction  out  1  shift_register control; direction 1 = right shift by count, 0 = normalize left.
REQ-013 sr_mantissa, sr_exponent, sr_no_of_shifts  out  Mantissa_Size+1, Exponent_Size, Exponent_Size  shift_register load data.
REQ-014 sr_shiftedMantissa, sr_shiftedExponent, sr_done  in  Mantissa_Size+1, Exponent_Size, 1  shift_register results.

Function
REQ-015 FSM states SHALL be IDLE, COMPARE, ALIGN_LOAD, ALIGN_WAIT, ADD, NORM_LOAD, NORM_WAIT, DONE.
REQ-016 IDLE->COMPARE on start; a start pulse while busy SHALL be ignored.
REQ-017 COMPARE SHALL register operands, swap them so that A has the larger exponent (A wins ties), and compute diff = exp_a - exp_b.
REQ-018 diff==0 -> ADD, with no sr_load; diff > Mantissa_Size+1 -> smaller mantissa forced to 0, then ADD, with no sr_load; otherwise -> ALIGN_LOAD.
REQ-019 ALIGN_LOAD SHALL assert sr_load for exactly one cycle with sr_direction=1, sr_no_of_shifts=diff, and the smaller operand's mantissa/exponent.
REQ-020 In the WAIT states, sr_done SHALL be sampled only from the second cycle after sr_load falls, to reject a stale done; the aligned mantissa is captured on sr_done.
REQ-021 ADD SHALL form a Mantissa_Size+2-bit sum; on carry, mantissa = sum>>1 (LSB truncated) and exponent+1.
REQ-022 An exponent increment reaching all-ones SHALL set overflow, exponent all-ones, mantissa 0, and go to DONE.
REQ-023 Sum==0 -> DONE with mantissa 0 and exponent 0; sum MSB set -> DONE; otherwise -> NORM_LOAD.
REQ-024 NORM_LOAD SHALL pulse sr_load with sr_direction=0; NORM_WAIT captures the shifted result; a returned 0/0 SHALL set underflow.
REQ-025 DONE SHALL pulse result_valid for one cycle, then return to IDLE; sr_enable SHALL be high whenever busy.

Reset
REQ-026 reset_n low SHALL force IDLE at any time, including mid-operation, and clear all outputs, sr_load and the flags to 0.

Configuration
REQ-027 With SHIFT_TIMEOUT_EN defined, a counter in each WAIT state SHALL abort after Mantissa_Size+4 cycles without sr_done, going to DONE with both flags set and the result set to 0.
REQ-028 Without SHIFT_TIMEOUT_EN, the WAIT states SHALL wait indefinitely and the counter SHALL be absent.

Structure
REQ-029 Package fp_pkg SHALL hold the FSM state enum and the default Mantissa_Size/Exponent_Size constants.
REQ-030 The compare/swap/diff logic SHALL be sub-module fp_exp_compare; the shift_register is instantiated outside this block.

Verification (24-bit mantissa, 8-bit exponent; shift_register model attached)
REQ-031 A=0xC00000/e6, B=0x800000/e5 -> one align shift of 1, carry -> 0x800000, e7, no flags.
REQ-032 A=B=0x800000/e10 -> no sr_load pulses, result 0x800000, e11.
REQ-033 A=B=0x030000/e6 -> sum 0x060000, normalize -> 0xC00000, e1, underflow=0.
REQ-034 A=B=0x030000/e2 -> normalize underflows -> 0x000000, e0, underflow=1.
REQ-035 A=0x800000/e40, B=0xFFFFFF/e10 (diff 30) -> no sr_load, result 0x800000, e40; A=B=0x800000/e254 -> overflow=1, e0xFF, mantissa 0.
REQ-036 reset_n low during ALIGN_WAIT -> IDLE next edge, busy=0; with SHIFT_TIMEOUT_EN and sr_done tied 0 -> result_valid 28 cycles after sr_load falls, both flags set.
